// File: rtl/cache_fill_controller_pkg.sv
// ============================================================================
// Module      : cache_fill_pkg
// Description : Shared constants and FSM state encodings for the block-refill
//               controller (cache_fill_controller).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_fill_pkg;

    localparam int WORDS       = 8;
    localparam int MEM_LAT     = 4;
    localparam int OFFSET_BITS = $clog2(WORDS) + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL_I = 2'd1;
    localparam logic [1:0] FILL_D = 2'd2;

endpackage

`default_nettype wire

// File: rtl/cache_fill_controller_if.sv
// ============================================================================
// Module      : cache_fill_controller_if
// Description : Cache-side, store and memory-port signals of the refill
//               controller. master = controller, slave = caches + memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_fill_controller_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
);
    localparam int IDX_W = $clog2(WORDS);

    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              store_req;
    logic [ADDR_W-1:0] store_addr;
    logic [DATA_W-1:0] store_data;
    logic              store_ready;
    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_data_valid;
    logic [DATA_W-1:0] fill_data;
    logic [IDX_W-1:0]  fill_word_idx;
    logic              i_fill_we;
    logic              d_fill_we;
    logic              i_fill_done;
    logic              d_fill_done;
    logic              busy;

    modport master (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  store_req, store_addr, store_data,
        input  mem_rdata, mem_data_valid,
        output store_ready, mem_enable, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word_idx, i_fill_we, d_fill_we,
        output i_fill_done, d_fill_done, busy
    );

    modport slave (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output store_req, store_addr, store_data,
        output mem_rdata, mem_data_valid,
        input  store_ready, mem_enable, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word_idx, i_fill_we, d_fill_we,
        input  i_fill_done, d_fill_done, busy
    );

endinterface

`default_nettype wire

// File: rtl/cache_fill_controller_fill_word_counter.sv
// ============================================================================
// Module      : fill_word_counter
// Description : Word counter for one block; word = (count + start) mod WORDS,
//               last flags the final count value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fill_word_counter #(
    parameter int WORDS = 8,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             inc,
    input  wire logic [IDX_W-1:0] start,
    output logic      [IDX_W-1:0] word,
    output logic                  last
);

    logic [IDX_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Truncating add gives the wrap within the block for free.
    assign word = r_count + start;
    assign last = (r_count == IDX_W'(WORDS - 1));

endmodule

`default_nettype wire

// File: rtl/cache_fill_controller.sv
// ============================================================================
// Module      : cache_fill_controller
// Description : Block refill sequencer for I/D caches over the shared
//               pipelined memory, with write-through store arbitration.
//               Optional macro FILL_CRITICAL_WORD_FIRST_EN starts each
//               fill at the missed word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_controller #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = cache_fill_pkg::WORDS
) (
    input  wire logic               clk,
    input  wire logic               rst,
    cache_fill_controller_if.master bus
);
    import cache_fill_pkg::*;

    localparam int                IDX_W        = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] c_BLOCK_MASK = ADDR_W'(2 * WORDS - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]  r_start;
    logic              r_issued;
    logic              w_accept;
    logic [ADDR_W-1:0] w_miss_addr;
    logic              w_filling;
    logic              w_issue_inc;
    logic              w_recv_inc;
    logic              w_recv_end;
    logic [IDX_W-1:0]  w_issue_word;
    logic [IDX_W-1:0]  w_recv_word;
    logic              w_issue_last;
    logic              w_recv_last;

    assign w_filling   = (r_state != IDLE);
    assign w_accept    = (r_state == IDLE) && !bus.store_req && (bus.i_miss || bus.d_miss);
    assign w_miss_addr = bus.i_miss ? bus.i_miss_addr : bus.d_miss_addr;
    assign w_issue_inc = w_filling && !r_issued;
    assign w_recv_inc  = w_filling && bus.mem_data_valid;
    assign w_recv_end  = w_recv_inc && w_recv_last;

    fill_word_counter #(.WORDS(WORDS), .IDX_W(IDX_W)) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!w_filling),
        .inc   (w_issue_inc),
        .start (r_start),
        .word  (w_issue_word),
        .last  (w_issue_last)
    );

    fill_word_counter #(.WORDS(WORDS), .IDX_W(IDX_W)) u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!w_filling),
        .inc   (w_recv_inc),
        .start (r_start),
        .word  (w_recv_word),
        .last  (w_recv_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base  <= '0;
            r_start <= '0;
        end else if (w_accept) begin
            r_base  <= w_miss_addr & ~c_BLOCK_MASK;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
            r_start <= w_miss_addr[IDX_W:1];
`else
            r_start <= '0;
`endif
        end
    end

    // Issue side stops after WORDS reads while the receive side drains.
    always_ff @(posedge clk) begin
        if (rst || !w_filling) begin
            r_issued <= 1'b0;
        end else if (w_issue_inc && w_issue_last) begin
            r_issued <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (!bus.store_req) begin
                    if (bus.i_miss) begin
                        w_next = FILL_I;
                    end else if (bus.d_miss) begin
                        w_next = FILL_D;
                    end
                end
            end
            FILL_I, FILL_D: begin
                if (w_recv_end) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.store_ready   = 1'b0;
        bus.mem_enable    = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.fill_data     = '0;
        bus.fill_word_idx = '0;
        bus.i_fill_we     = 1'b0;
        bus.d_fill_we     = 1'b0;
        bus.i_fill_done   = 1'b0;
        bus.d_fill_done   = 1'b0;
        bus.busy          = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.store_req && !rst) begin
                    bus.store_ready = 1'b1;
                    bus.mem_enable  = 1'b1;
                    bus.mem_wr      = 1'b1;
                    bus.mem_addr    = bus.store_addr;
                    bus.mem_wdata   = bus.store_data;
                end
            end
            FILL_I, FILL_D: begin
                bus.busy          = 1'b1;
                bus.mem_enable    = !r_issued;
                bus.mem_addr      = r_base | ADDR_W'({w_issue_word, 1'b0});
                bus.fill_data     = bus.mem_rdata;
                bus.fill_word_idx = w_recv_word;
                bus.i_fill_we     = (r_state == FILL_I) && bus.mem_data_valid;
                bus.d_fill_we     = (r_state == FILL_D) && bus.mem_data_valid;
                bus.i_fill_done   = (r_state == FILL_I) && w_recv_end;
                bus.d_fill_done   = (r_state == FILL_D) && w_recv_end;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_controller.sv
// ============================================================================
// Module      : tb_cache_fill_controller
// Description : Self-checking bench for cache_fill_controller with a
//               MEM_LAT-deep pipelined memory model and timing reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_fill_controller;
    import cache_fill_pkg::*;

    localparam int W     = WORDS;
    localparam int LAT   = MEM_LAT;
    localparam int IDX_W = OFFSET_BITS - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_fill_controller_if #(.ADDR_W(16), .DATA_W(16), .WORDS(W)) bus ();

    cache_fill_controller #(.ADDR_W(16), .DATA_W(16), .WORDS(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] key;
    logic        spurious;

    logic [LAT-1:0] vpipe;
    logic [15:0]    dpipe [LAT];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ key ^ {a[7:0], a[15:8]};
    endfunction

    // Memory model: read data appears MEM_LAT cycles after the issue cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
            for (int i = 0; i < LAT; i++) dpipe[i] <= '0;
        end else begin
            vpipe    <= {vpipe[LAT-2:0], bus.mem_enable & ~bus.mem_wr};
            dpipe[0] <= mem_word(bus.mem_addr);
            for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
        end
    end

    assign bus.mem_data_valid = vpipe[LAT-1] | spurious;
    assign bus.mem_rdata      = dpipe[LAT-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_check(input bit is_d, input logic [15:0] addr, input bit stall);
        logic [15:0]      base;
        logic [IDX_W-1:0] start;
        logic [IDX_W-1:0] idx;
        bit               exp_en;
        bit               exp_we;
        base  = addr & ~16'(2 * W - 1);
        start = '0;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
        start = addr[IDX_W:1];
`endif
        if (is_d) begin
            bus.d_miss = 1'b1; bus.d_miss_addr = addr;
        end else begin
            bus.i_miss = 1'b1; bus.i_miss_addr = addr;
        end
        for (int c = 0; c <= W + LAT; c++) begin
            if (c > 0) next_cycle();
            if (stall) begin
                bus.store_req  = (c >= 2 && c <= 5);
                bus.store_addr = 16'($urandom);
                bus.store_data = 16'($urandom);
            end
            @(negedge clk);
            check_eq("busy", bus.busy, c > 0);
            check_eq("store_ready", bus.store_ready, 1'b0);
            exp_en = (c >= 1 && c <= W);
            check_eq("mem_enable", bus.mem_enable, exp_en);
            if (exp_en) begin
                idx = IDX_W'((c - 1 + int'(start)) % W);
                check_eq("mem_addr", bus.mem_addr, base + 16'({idx, 1'b0}));
                check_eq("mem_wr", bus.mem_wr, 1'b0);
            end
            exp_we = (c >= LAT + 1 && c <= W + LAT);
            check_eq("i_fill_we", bus.i_fill_we, exp_we && !is_d);
            check_eq("d_fill_we", bus.d_fill_we, exp_we && is_d);
            if (exp_we) begin
                idx = IDX_W'((c - 1 - LAT + int'(start)) % W);
                check_eq("fill_word_idx", bus.fill_word_idx, idx);
                check_eq("fill_data", bus.fill_data, mem_word(base + 16'({idx, 1'b0})));
            end
            check_eq("i_fill_done", bus.i_fill_done, (c == W + LAT) && !is_d);
            check_eq("d_fill_done", bus.d_fill_done, (c == W + LAT) && is_d);
        end
        next_cycle();
        if (is_d) bus.d_miss = 1'b0;
        else      bus.i_miss = 1'b0;
    endtask

    task automatic store_cycle(input logic [15:0] addr, input logic [15:0] data);
        bus.store_req  = 1'b1;
        bus.store_addr = addr;
        bus.store_data = data;
        @(negedge clk);
        check_eq("st_ready", bus.store_ready, 1'b1);
        check_eq("st_enable", bus.mem_enable, 1'b1);
        check_eq("st_wr", bus.mem_wr, 1'b1);
        check_eq("st_addr", bus.mem_addr, addr);
        check_eq("st_wdata", bus.mem_wdata, data);
        check_eq("st_busy", bus.busy, 1'b0);
        next_cycle();
        bus.store_req = 1'b0;
    endtask

    task automatic idle_spurious();
        spurious = 1'b1;
        @(negedge clk);
        check_eq("idle_i_we", bus.i_fill_we, 1'b0);
        check_eq("idle_d_we", bus.d_fill_we, 1'b0);
        check_eq("idle_busy", bus.busy, 1'b0);
        next_cycle();
        spurious = 1'b0;
    endtask

    task automatic reset_mid_fill(input logic [15:0] addr);
        bus.d_miss      = 1'b1;
        bus.d_miss_addr = addr;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            if (c == 3) begin
                @(negedge clk);
                check_eq("rst_pre_busy", bus.busy, 1'b1);
            end
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        fill_check(1'b1, addr, 1'b0);
    endtask

    initial begin
        int          kind;
        logic [15:0] a1;
        logic [15:0] a2;
        bit          stall;
        key             = 16'($urandom);
        spurious        = 1'b0;
        rst             = 1'b1;
        bus.i_miss      = 1'b0;
        bus.i_miss_addr = '0;
        bus.d_miss      = 1'b0;
        bus.d_miss_addr = '0;
        bus.store_req   = 1'b0;
        bus.store_addr  = '0;
        bus.store_data  = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_mem_enable", bus.mem_enable, 1'b0);
        check_eq("rst_store_ready", bus.store_ready, 1'b0);
        check_eq("rst_i_we", bus.i_fill_we, 1'b0);
        check_eq("rst_d_we", bus.d_fill_we, 1'b0);
        check_eq("rst_done", {bus.i_fill_done, bus.d_fill_done}, 2'b00);
        next_cycle();
        rst = 1'b0;

        fill_check(1'b0, 16'h1236, 1'b0);

        bus.d_miss = 1'b1; bus.d_miss_addr = 16'h2468;
        fill_check(1'b0, 16'h0F02, 1'b0);
        fill_check(1'b1, 16'h2468, 1'b0);

        bus.i_miss = 1'b1; bus.i_miss_addr = 16'h5554;
        store_cycle(16'h7000, 16'hBEEF);
        fill_check(1'b0, 16'h5554, 1'b1);

        reset_mid_fill(16'h004A);
        idle_spurious();
        fill_check(1'b1, 16'h004A, 1'b0);

        for (int it = 0; it < 25; it++) begin
            kind  = int'($urandom_range(0, 4));
            a1    = 16'($urandom);
            a2    = 16'($urandom);
            stall = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) idle_spurious();
            case (kind)
                0: fill_check(1'b0, a1, stall);
                1: fill_check(1'b1, a1, stall);
                2: begin
                    bus.d_miss = 1'b1; bus.d_miss_addr = a2;
                    fill_check(1'b0, a1, stall);
                    fill_check(1'b1, a2, 1'b0);
                end
                3: begin
                    if (stall) begin
                        bus.d_miss = 1'b1; bus.d_miss_addr = a1;
                    end else begin
                        bus.i_miss = 1'b1; bus.i_miss_addr = a1;
                    end
                    store_cycle(a2, 16'($urandom));
                    fill_check(stall, a1, 1'b0);
                end
                default: reset_mid_fill(a1);
            endcase
        end

        @(negedge clk);
        check_eq("final_busy", bus.busy, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cache_fill_controller.md
Name: cache_fill_controller

Overview:
Sequences block refills for the I-cache and D-cache over the shared 4-cycle pipelined memory (memory4c), and arbitrates single-word write-through stores onto the same port. On a miss it issues one word read per cycle for the whole block and streams the returned words, tagged with their word index, into the requesting cache's data array. It sits between both caches and the memory instance, replacing a one-word-per-miss controller.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 16, word width
WORDS, 8, words per cache block (power of 2)
MEM_LAT, 4, cycles from an accepted read issue to mem_data_valid

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_miss  in  1  I-cache miss request, held until i_fill_done
i_miss_addr  in  ADDR_W  I-cache miss byte address
d_miss  in  1  D-cache miss request, held until d_fill_done
d_miss_addr  in  ADDR_W  D-cache miss byte address
store_req  in  1  write-through store request
store_addr  in  ADDR_W  store byte address
store_data  in  DATA_W  store data
store_ready  out  1  store accepted this cycle
mem_enable  out  1  memory enable
mem_wr  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_data_valid  in  1  memory read data valid
fill_data  out  DATA_W  returned word, to both caches
fill_word_idx  out  log2(WORDS)  word index within the block
i_fill_we  out  1  write fill_data into the I-cache
d_fill_we  out  1  write fill_data into the D-cache
i_fill_done  out  1  one-cycle pulse on the last I word
d_fill_done  out  1  one-cycle pulse on the last D word
busy  out  1  state != IDLE

Behaviour:
- This block has one clock; reset is synchronous and active-high. Ports are named clk and rst.
- States: IDLE, FILL_I, FILL_D. On reset: IDLE, counters 0, all outputs 0.
- IDLE priority:
  - store_req: store_ready=1, mem_enable=1, mem_wr=1, mem_addr=store_addr, mem_wdata=store_data. Stay in IDLE.
  - else i_miss: latch base = i_miss_addr with the low log2(WORDS*2) bits cleared, go to FILL_I.
  - else d_miss: latch base the same way, go to FILL_D.
- FILL_x:
  - issue_cnt runs 0..WORDS-1. While issue_cnt < WORDS: mem_enable=1, mem_wr=0, mem_addr = base + 2*word(issue_cnt); issue_cnt increments.
  - After the last issue, mem_enable=0.
  - recv_cnt increments on each mem_data_valid. Memory returns words in order.
  - fill_data=mem_rdata and fill_word_idx=word(recv_cnt). x_fill_we = mem_data_valid.
  - When recv_cnt==WORDS-1 and mem_data_valid: x_fill_done=1 that cycle; next state IDLE; both counters clear.
- Stores during FILL_x: store_ready=0 (store stalls).
- Miss requests are sampled only in IDLE. A miss arriving mid-fill waits.
- Latency (miss seen in IDLE at cycle 0):
  - issues at cycles 1..WORDS;
  - data at cycles 1+MEM_LAT..WORDS+MEM_LAT;
  - done at cycle 12 with defaults;
  - IDLE at cycle 13, and a new request may be accepted in that cycle.
- mem_data_valid in IDLE is ignored; no fill_we is asserted.
- rst mid-fill: the next cycle is IDLE with counters 0. In-flight memory data is ignored because memory4c resets too. A still-asserted miss restarts a full fill.
- Address arithmetic wraps within the block: word(n) = (n + start) mod WORDS. start = 0 unless the optional feature is enabled.

Optional Feature:
FILL_CRITICAL_WORD_FIRST_EN
- Defined: start = miss_addr[log2(WORDS):1], latched on accept. Issue and return order begin at the missed word and wrap. fill_word_idx carries the true index.
- Undefined: start = 0, linear order 0..WORDS-1.

Decomposition:
- Package cache_fill_pkg: state encodings (IDLE=0, FILL_I=1, FILL_D=2), WORDS, MEM_LAT, the OFFSET_BITS constant.
- One natural sub-module, fill_word_counter: a log2(WORDS)-bit counter with a start offset and a last flag. It is instantiated twice, once for issue and once for receive.

Test Plan:
- i_miss=1, i_miss_addr=0x1236, with a MEM_LAT=4 memory model → issues 0x1230..0x123E on cycles 1..8; i_fill_we at cycles 5..12 with idx 0..7; i_fill_done pulse at cycle 12; busy=0 at cycle 13.
- i_miss and d_miss asserted together → I fill completes first, then D fill starts on the next IDLE cycle; d_fill_we is never asserted during FILL_I.
- store_req and i_miss in the same IDLE cycle → store_ready=1, mem_wr=1 with store_addr; FILL_I entered the next cycle. store_req during a fill → store_ready=0 until IDLE.
- rst asserted at cycle 6 of a D fill → cycle 7 has busy=0 and no fill_we; a held d_miss restarts with 8 fresh issues.
- With FILL_CRITICAL_WORD_FIRST_EN, d_miss_addr=0x004A → issue order 0x004A, 0x004C, 0x004E, 0x0040..0x0048; fill_word_idx 5,6,7,0..4.
